img_readout_buffer: RTL and testbench

- Sits directly downstream of the image controller's readout port (16-bit ready/trigger stream) and upstream of the SD write path.
- Buffers readout words in an on-chip FIFO and reports 512-byte chunk availability, so the SD side only starts a block write when a whole chunk can be drained without stalling.
- Caps intake at a programmed total word count and flags completion.

---
 rtl/img_readout_buffer_pkg.sv | 28 ++
 rtl/img_readout_fifo_ram.sv | 32 +++
 rtl/img_readout_buffer.sv | 146 ++++++++++++++
 tb/tb_img_readout_buffer.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_readout_buffer_pkg.sv
// Shared sizing constants, FSM state type and session-length helpers for the
// image readout buffer.
package img_readout_buffer_pkg;

  localparam int IMG_READOUT_CHUNK_WORDS  = 256;        // one 512-byte SD block
  localparam int IMG_READOUT_BUFFER_WORDS = 512;        // FIFO depth in 16-bit words
  localparam int IMG_MAX_WORD_COUNT       = 2_500_000;  // largest session length
  localparam int IMG_HEADER_WORD_COUNT    = 16;
  localparam int IMG_CHECKSUM_WORDS       = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } readout_state_t;

  // Bits needed to hold any value 0..max_value.
  function automatic int reg_width(input int max_value);
    return $clog2(max_value + 1);
  endfunction

  // Total words in one session: header + image payload + checksum + padding.
  function automatic int img_total_words(input int img_words, input int pad_words);
    return IMG_HEADER_WORD_COUNT + img_words + IMG_CHECKSUM_WORDS + pad_words;
  endfunction

endpackage

// File: rtl/img_readout_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on
// contents so it maps onto embedded block RAM.
module img_readout_fifo_ram
  import img_readout_buffer_pkg::*;
#(
  parameter int Depth = IMG_READOUT_BUFFER_WORDS,
  parameter int Width = 16
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(Depth)-1:0] i_wr_addr,
  input  logic [Width-1:0]         i_wr_data,
  input  logic [$clog2(Depth)-1:0] i_rd_addr,
  output logic [Width-1:0]         o_rd_data
);

  logic [Width-1:0] r_mem [Depth];
  logic [Width-1:0] r_rd_data;

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Registered read port (old data returned on a same-address write)
  always_ff @(posedge clk) begin
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/img_readout_buffer.sv
// Readout buffer between the image controller and the SD write path: FWFT FIFO
// over block RAM, session word counting, and chunk-availability reporting.
module img_readout_buffer
  import img_readout_buffer_pkg::*;
#(
  parameter int WordCapacity = IMG_READOUT_BUFFER_WORDS,
  parameter int ChunkWords   = IMG_READOUT_CHUNK_WORDS,
  parameter int MaxWordCount = IMG_MAX_WORD_COUNT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_cfg_start,
  input  logic [reg_width(MaxWordCount)-1:0] i_cfg_wordCount,
  input  logic                              i_in_ready,
  input  logic [15:0]                       i_in_data,
  output logic                              o_in_trigger,
  output logic                              o_out_ready,
  output logic [15:0]                       o_out_data,
  input  logic                              i_out_trigger,
  output logic                              o_status_chunkReady,
  output logic                              o_status_done,
  output logic                              o_status_overflow
);

  localparam int AW = $clog2(WordCapacity);
  localparam int PW = AW + 1;
  localparam int CW = reg_width(MaxWordCount);
  localparam logic [PW-1:0] CAP   = PW'(WordCapacity);
  localparam logic [PW-1:0] CHUNK = PW'(ChunkWords);

  readout_state_t r_state;
  logic [PW-1:0]  r_wptr, r_rptr;
  logic [CW-1:0]  r_in_count, r_out_count, r_word_count;
  logic           r_chunk_ready, r_done, r_overflow;
  logic           r_byp_valid;
  logic [15:0]    r_byp_data;

  logic [PW-1:0]  w_fill, w_wptr_next, w_rptr_next, w_fill_next;
  logic [CW-1:0]  w_in_count_next, w_out_count_next;
  logic           w_in_trigger, w_out_ready, w_push, w_pop, w_full, w_drain_next;
  logic [15:0]    w_ram_q;
  logic [AW-1:0]  w_rd_addr;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign w_fill       = r_wptr - r_rptr;
  assign w_full       = (w_fill == CAP);
  assign w_in_trigger = (r_state == ST_ACTIVE) && !w_full && (r_in_count < r_word_count);
  assign w_out_ready  = (w_fill != '0);

  // A restart cycle discards whatever handshake coincides with it.
  assign w_push = i_in_ready && w_in_trigger && !i_cfg_start;
  assign w_pop  = w_out_ready && i_out_trigger && !i_cfg_start;

  assign w_wptr_next      = r_wptr + {{(PW-1){1'b0}}, w_push};
  assign w_rptr_next      = r_rptr + {{(PW-1){1'b0}}, w_pop};
  assign w_fill_next      = i_cfg_start ? '0 : (w_wptr_next - w_rptr_next);
  assign w_in_count_next  = r_in_count + {{(CW-1){1'b0}}, w_push};
  assign w_out_count_next = r_out_count + {{(CW-1){1'b0}}, w_pop};

  // Session will be in the drain phase after this edge (last word accepted).
  assign w_drain_next = !i_cfg_start &&
                        (((r_state == ST_ACTIVE) && (w_in_count_next == r_word_count)) ||
                         (r_state == ST_DRAIN));

  // The RAM is read at the post-pop head so its registered output is the head next cycle.
  assign w_rd_addr = i_cfg_start ? '0 : w_rptr_next[AW-1:0];

  img_readout_fifo_ram #(
    .Depth (WordCapacity),
    .Width (16)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wptr[AW-1:0]),
    .i_wr_data (i_in_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_ram_q)
  );

  // Bypass the RAM when the word written now is the one being read as the new head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byp_valid <= 1'b0;
      r_byp_data  <= '0;
    end else begin
      r_byp_valid <= w_push && (r_wptr == w_rptr_next);
      r_byp_data  <= i_in_data;
    end
  end

  // Session FSM, pointers, counters and registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_in_count    <= '0;
      r_out_count   <= '0;
      r_word_count  <= '0;
      r_chunk_ready <= 1'b0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_wptr        <= w_wptr_next;
      r_rptr        <= w_rptr_next;
      r_in_count    <= w_in_count_next;
      r_out_count   <= w_out_count_next;
      r_chunk_ready <= (w_fill_next >= CHUNK) || (w_drain_next && (w_fill_next != '0));
      if (w_push && w_full) r_overflow <= 1'b1;

      if (i_cfg_start) begin
        r_wptr       <= '0;
        r_rptr       <= '0;
        r_in_count   <= '0;
        r_out_count  <= '0;
        r_word_count <= i_cfg_wordCount;
        if (i_cfg_wordCount == '0) begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end else begin
          r_state <= ST_ACTIVE;
          r_done  <= 1'b0;
        end
      end else begin
        case (r_state)
          ST_ACTIVE: if (w_in_count_next == r_word_count) r_state <= ST_DRAIN;
          ST_DRAIN: begin
            if (w_out_count_next == r_word_count) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_in_trigger        = w_in_trigger;
  assign o_out_ready         = w_out_ready;
  assign o_out_data          = w_out_ready ? (r_byp_valid ? r_byp_data : w_ram_q) : '0;
  assign o_status_chunkReady = r_chunk_ready;
  assign o_status_done       = r_done;
  assign o_status_overflow   = r_overflow;

endmodule

// File: tb/tb_img_readout_buffer.sv
// Scenario bench for img_readout_buffer: every accepted word is queued as the
// expected output and checked when it is popped.
module tb_img_readout_buffer;
  import img_readout_buffer_pkg::*;

  localparam int CW = reg_width(IMG_MAX_WORD_COUNT);

  logic          clk, rst, i_cfg_start, i_in_ready, i_out_trigger;
  logic [CW-1:0] i_cfg_wordCount;
  logic [15:0]   i_in_data;
  logic          o_in_trigger, o_out_ready, o_status_chunkReady, o_status_done, o_status_overflow;
  logic [15:0]   o_out_data;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] sb [$];
  logic        pu, po;
  logic [15:0] pd, exp;

  img_readout_buffer dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_cfg_start         (i_cfg_start),
    .i_cfg_wordCount     (i_cfg_wordCount),
    .i_in_ready          (i_in_ready),
    .i_in_data           (i_in_data),
    .o_in_trigger        (o_in_trigger),
    .o_out_ready         (o_out_ready),
    .o_out_data          (o_out_data),
    .i_out_trigger       (i_out_trigger),
    .o_status_chunkReady (o_status_chunkReady),
    .o_status_done       (o_status_done),
    .o_status_overflow   (o_status_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // Called at a falling edge: predicts the handshakes of the coming rising edge,
  // queues accepted words, drives inputs and advances to the next falling edge.
  task automatic step(input logic ir, input logic [15:0] d, input logic ot,
                      output logic pushed, output logic popped, output logic [15:0] pdata);
    pushed = ir && o_in_trigger;
    popped = ot && o_out_ready;
    pdata  = o_out_data;
    i_in_ready    = ir;
    i_in_data     = d;
    i_out_trigger = ot;
    if (pushed) sb.push_back(d);
    @(negedge clk);
    i_in_ready    = 1'b0;
    i_out_trigger = 1'b0;
  endtask

  task automatic start_session(input int count);
    i_cfg_start     = 1'b1;
    i_cfg_wordCount = CW'(count);
    i_in_ready      = 1'b0;
    i_out_trigger   = 1'b0;
    @(negedge clk);
    i_cfg_start = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; i_cfg_start = 1'b0; i_cfg_wordCount = '0;
    i_in_ready = 1'b0; i_in_data = '0; i_out_trigger = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({o_in_trigger, o_out_ready, o_status_chunkReady, o_status_done, o_status_overflow} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got trig/rdy/chunk/done/ovf=%b required 00000",
               {o_in_trigger, o_out_ready, o_status_chunkReady, o_status_done, o_status_overflow});
    end
    n_tests++;
    if (o_out_data !== 16'h0) begin
      n_fail++; $display("FAIL reset_out_data: got %h required 0000", o_out_data);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (o_in_trigger !== 1'b0 || o_out_ready !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got trig=%b rdy=%b required 0 0", o_in_trigger, o_out_ready);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_reset_midstream();
    start_session(200);
    for (int i = 0; i < 100; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, pu, po, pd);
    n_tests++;
    if (o_out_ready !== 1'b1) begin
      n_fail++; $display("FAIL midstream_fill: got out_ready=%b required 1", o_out_ready);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({o_out_ready, o_in_trigger, o_status_chunkReady} !== 3'b0 || o_out_data !== 16'h0) begin
      n_fail++;
      $display("FAIL midstream_reset: got rdy/trig/chunk=%b data=%h required 000 0000",
               {o_out_ready, o_in_trigger, o_status_chunkReady}, o_out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'hDEAD, 1'b1, pu, po, pd);
      n_tests++;
      if (pu !== 1'b0 || po !== 1'b0) begin
        n_fail++; $display("FAIL idle_no_start: got push=%b pop=%b required 0 0", pu, po);
      end
    end
    $display("[TB] test_reset_midstream done");
  endtask

  task automatic test_exact_chunk();
    start_session(256);
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin
        n_tests++;
        if (o_status_chunkReady !== 1'b0) begin
          n_fail++; $display("FAIL chunk_early: got %b required 0 at 255 words", o_status_chunkReady);
        end
      end
      step(1'b1, 16'h0FFF - 16'(i), 1'b0, pu, po, pd);
      n_tests++;
      if (pu !== 1'b1) begin
        n_fail++; $display("FAIL chunk_push_%0d: got in_trigger=%b required 1", i, pu);
      end
    end
    n_tests++;
    if ({o_status_chunkReady, o_in_trigger, o_out_ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL chunk_full: got chunk/trig/rdy=%b required 101",
               {o_status_chunkReady, o_in_trigger, o_out_ready});
    end
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 16'h0, 1'b1, pu, po, pd);
      n_tests++;
      if (po !== 1'b1 || sb.size() == 0) begin
        n_fail++; $display("FAIL chunk_pop_%0d: got out_ready=%b required 1", i, po);
      end else begin
        exp = sb.pop_front();
        if (pd !== exp) begin
          n_fail++; $display("FAIL chunk_data_%0d: got %h required %h", i, pd, exp);
        end
      end
    end
    n_tests++;
    if (o_status_done !== 1'b1 || o_out_ready !== 1'b0) begin
      n_fail++; $display("FAIL chunk_done: got done=%b rdy=%b required 1 0", o_status_done, o_out_ready);
    end
    $display("[TB] test_exact_chunk done");
  endtask

  task automatic test_backpressure();
    int cnt;
    cnt = 0;
    start_session(1000);
    for (int i = 0; i < 600; i++) begin
      step(1'b1, 16'(i), 1'b0, pu, po, pd);
      if (pu) cnt++;
    end
    n_tests++;
    if (cnt != 512 || o_in_trigger !== 1'b0) begin
      n_fail++; $display("FAIL bp_capacity: got pushes=%0d trig=%b required 512 0", cnt, o_in_trigger);
    end
    step(1'b1, 16'hAAAA, 1'b1, pu, po, pd);
    n_tests++;
    if (pu !== 1'b0 || po !== 1'b1 || sb.size() == 0) begin
      n_fail++; $display("FAIL bp_pop_full: got push=%b pop=%b required 0 1", pu, po);
    end else begin
      exp = sb.pop_front();
      if (pd !== exp) begin
        n_fail++; $display("FAIL bp_pop_data: got %h required %h", pd, exp);
      end
    end
    step(1'b1, 16'hBBBB, 1'b0, pu, po, pd);
    n_tests++;
    if (pu !== 1'b1) begin
      n_fail++; $display("FAIL bp_refill: got push=%b required 1", pu);
    end
    step(1'b1, 16'hCCCC, 1'b0, pu, po, pd);
    n_tests++;
    if (pu !== 1'b0 || o_status_overflow !== 1'b0) begin
      n_fail++; $display("FAIL bp_single_slot: got push=%b ovf=%b required 0 0", pu, o_status_overflow);
    end
    $display("[TB] test_backpressure done");
  endtask

  task automatic test_partial_chunk();
    start_session(300);
    for (int i = 0; i < 256; i++) step(1'b1, 16'h3000 + 16'(i), 1'b0, pu, po, pd);
    n_tests++;
    if (o_status_chunkReady !== 1'b1) begin
      n_fail++; $display("FAIL partial_first_chunk: got %b required 1", o_status_chunkReady);
    end
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 16'h0, 1'b1, pu, po, pd);
      n_tests++;
      if (po !== 1'b1 || sb.size() == 0) begin
        n_fail++; $display("FAIL partial_pop_%0d: got out_ready=%b required 1", i, po);
      end else begin
        exp = sb.pop_front();
        if (pd !== exp) begin
          n_fail++; $display("FAIL partial_data_%0d: got %h required %h", i, pd, exp);
        end
      end
    end
    n_tests++;
    if (o_status_chunkReady !== 1'b0 || o_out_ready !== 1'b0) begin
      n_fail++; $display("FAIL partial_drained: got chunk=%b rdy=%b required 0 0", o_status_chunkReady, o_out_ready);
    end
    for (int i = 0; i < 44; i++) begin
      step(1'b1, 16'h4000 + 16'(i), 1'b0, pu, po, pd);
      n_tests++;
      if (pu !== 1'b1) begin
        n_fail++; $display("FAIL partial_tail_push_%0d: got %b required 1", i, pu);
      end
    end
    n_tests++;
    if (o_status_chunkReady !== 1'b1 || o_in_trigger !== 1'b0) begin
      n_fail++; $display("FAIL partial_tail_chunk: got chunk=%b trig=%b required 1 0", o_status_chunkReady, o_in_trigger);
    end
    for (int i = 0; i < 44; i++) begin
      step(1'b0, 16'h0, 1'b1, pu, po, pd);
      n_tests++;
      if (po !== 1'b1 || sb.size() == 0) begin
        n_fail++; $display("FAIL partial_tail_pop_%0d: got out_ready=%b required 1", i, po);
      end else begin
        exp = sb.pop_front();
        if (pd !== exp) begin
          n_fail++; $display("FAIL partial_tail_data_%0d: got %h required %h", i, pd, exp);
        end
      end
    end
    n_tests++;
    if (o_status_done !== 1'b1 || o_status_chunkReady !== 1'b0) begin
      n_fail++; $display("FAIL partial_done: got done=%b chunk=%b required 1 0", o_status_done, o_status_chunkReady);
    end
    $display("[TB] test_partial_chunk done");
  endtask

  task automatic test_random_handshake();
    int   total, acc, popped, guard;
    logic ir, ot;
    total = img_total_words(600, 150);
    acc = 0; popped = 0; guard = 0;
    start_session(total);
    while (guard < 20000 && popped < total) begin
      guard++;
      ir = ($urandom_range(1) == 1);
      ot = ($urandom_range(1) == 1);
      if (acc == total) begin
        n_tests++;
        if (o_in_trigger !== 1'b0) begin
          n_fail++; $display("FAIL rand_trig_after_total: got %b required 0", o_in_trigger);
        end
      end
      step(ir, 16'($urandom), ot, pu, po, pd);
      if (pu) acc++;
      if (po) begin
        popped++;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL rand_extra_pop: got data %h required no word", pd);
        end else begin
          exp = sb.pop_front();
          if (pd !== exp) begin
            n_fail++; $display("FAIL rand_data_%0d: got %h required %h", popped, pd, exp);
          end
        end
      end
    end
    n_tests++;
    if (popped != total || acc != total) begin
      n_fail++; $display("FAIL rand_timeout: got accepted=%0d popped=%0d required %0d", acc, popped, total);
    end
    n_tests++;
    if (o_status_done !== 1'b1 || o_out_ready !== 1'b0 || o_status_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_done: got done=%b rdy=%b ovf=%b required 1 0 0", o_status_done, o_out_ready, o_status_overflow);
    end
    $display("[TB] test_random_handshake done (%0d words)", total);
  endtask

  task automatic test_restart();
    int cnt;
    cnt = 0;
    start_session(200);
    for (int i = 0; i < 37; i++) step(1'b1, 16'h5000 + 16'(i), 1'b0, pu, po, pd);
    i_cfg_start     = 1'b1;
    i_cfg_wordCount = CW'(5);
    i_in_ready      = 1'b1;
    i_in_data       = 16'hBAD0;
    i_out_trigger   = 1'b1;
    @(negedge clk);
    i_cfg_start = 1'b0; i_in_ready = 1'b0; i_out_trigger = 1'b0;
    sb.delete();
    n_tests++;
    if ({o_out_ready, o_status_done, o_status_chunkReady, o_in_trigger} !== 4'b0001 || o_out_data !== 16'h0) begin
      n_fail++;
      $display("FAIL restart_flush: got rdy/done/chunk/trig=%b data=%h required 0001 0000",
               {o_out_ready, o_status_done, o_status_chunkReady, o_in_trigger}, o_out_data);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 16'h6000 + 16'(i), 1'b0, pu, po, pd);
      if (pu) cnt++;
    end
    n_tests++;
    if (cnt != 5) begin
      n_fail++; $display("FAIL restart_count: got pushes=%0d required 5", cnt);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 16'h0, 1'b1, pu, po, pd);
      n_tests++;
      if (po !== 1'b1 || sb.size() == 0) begin
        n_fail++; $display("FAIL restart_pop_%0d: got out_ready=%b required 1", i, po);
      end else begin
        exp = sb.pop_front();
        if (pd !== exp) begin
          n_fail++; $display("FAIL restart_data_%0d: got %h required %h", i, pd, exp);
        end
      end
    end
    n_tests++;
    if (o_status_done !== 1'b1 || o_out_ready !== 1'b0) begin
      n_fail++; $display("FAIL restart_done: got done=%b rdy=%b required 1 0", o_status_done, o_out_ready);
    end
    $display("[TB] test_restart done");
  endtask

  task automatic test_zero_count();
    start_session(0);
    n_tests++;
    if (o_status_done !== 1'b1 || o_in_trigger !== 1'b0) begin
      n_fail++; $display("FAIL zero_done: got done=%b trig=%b required 1 0", o_status_done, o_in_trigger);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'h7777, 1'b0, pu, po, pd);
      n_tests++;
      if (pu !== 1'b0) begin
        n_fail++; $display("FAIL zero_no_trigger: got push=%b required 0", pu);
      end
    end
    start_session(3);
    n_tests++;
    if (o_status_done !== 1'b0 || o_in_trigger !== 1'b1) begin
      n_fail++; $display("FAIL zero_restart_clear: got done=%b trig=%b required 0 1", o_status_done, o_in_trigger);
    end
    $display("[TB] test_zero_count done");
  endtask

  initial begin
    test_reset();
    test_reset_midstream();
    test_exact_chunk();
    test_backpressure();
    test_partial_chunk();
    test_random_handshake();
    test_restart();
    test_zero_count();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
